stopwatch_bcd: RTL

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_bcd.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd.sv
// Tenths-resolution BCD stopwatch with up/down count, load, lap freeze
// and a registered 9-digit display frame with change strobe.
module stopwatch_bcd #(
   parameter int TICK_DIV  = 1000000,
   parameter int HOUR_WRAP = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        dir,
   input  logic        load,
   input  logic [23:0] load_val,
   input  logic        lap,
   output logic        running,
   output logic        done,
   output logic        upd,
   output logic [23:0] time_bcd,
   output logic [44:0] disp_data
);

   localparam int             PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PSC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [3:0]     H_MAX    = 4'(HOUR_WRAP - 1);
   localparam logic [4:0]     DASH     = 5'd17;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] psc_q;
   logic [PW-1:0] psc_d;
   logic [23:0]   time_d;
   logic          done_d;
   logic          tick;
   logic          time_zero;
   logic          freeze_q;
   logic [23:0]   frz_q;
   logic          init_q;
   logic [44:0]   disp_d;

   // Digit order inside the 24-bit word: 0=t 1=s 2=ts 3=m 4=tm 5=h
   function automatic logic [3:0] dig_lim(input int i);
      case (i)
         2, 4:    dig_lim = 4'd5;
         5:       dig_lim = H_MAX;
         default: dig_lim = 4'd9;
      endcase
   endfunction

   function automatic logic [23:0] count_up(input logic [23:0] v);
      logic [23:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= dig_lim(i)) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] count_down(input logic [23:0] v);
      logic [23:0] r;
      logic        b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = dig_lim(i);
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] sat(input logic [23:0] v);
      logic [23:0] r;
      for (int i = 0; i < 6; i++) begin
         if (v[4*i +: 4] > dig_lim(i)) begin
            r[4*i +: 4] = dig_lim(i);
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [44:0] fmt(input logic [23:0] v);
      fmt = {1'b0, v[3:0],   DASH,
             1'b0, v[7:4],   1'b0, v[11:8],  DASH,
             1'b0, v[15:12], 1'b0, v[19:16], DASH,
             1'b0, v[23:20]};
   endfunction

   assign running   = (state_q == ST_RUN);
   assign time_zero = (time_bcd == 24'h0);
   assign tick      = running && (psc_q == PSC_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         psc_q    <= '0;
         time_bcd <= '0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         psc_q    <= psc_d;
         time_bcd <= time_d;
         done     <= done_d;
      end
   end

   // Commands outrank the tick; only the start/idle branch lets it land.
   always_comb begin
      state_d = state_q;
      psc_d   = psc_q;
      time_d  = time_bcd;
      done_d  = 1'b0;
      priority case (1'b1)
         clear: begin
            state_d = ST_IDLE;
            psc_d   = '0;
            time_d  = '0;
         end
         load: begin
            state_d = ST_IDLE;
            psc_d   = '0;
            time_d  = sat(load_val);
         end
         stop: begin
            state_d = ST_IDLE;
         end
         default: begin
            if (start && !(dir && time_zero)) begin
               state_d = ST_RUN;
            end
            if (tick) begin
               psc_d = '0;
               if (dir) begin
                  time_d = count_down(time_bcd);
                  if (time_d == 24'h0) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  time_d = count_up(time_bcd);
               end
            end else if (running) begin
               psc_d = psc_q + PW'(1);
            end
         end
      endcase
   end

   assign disp_d = fmt(freeze_q ? frz_q : time_bcd);

   // init_q forces one upd after reset so the first frame gets written.
   always_ff @(posedge clk) begin
      if (rst) begin
         freeze_q  <= 1'b0;
         frz_q     <= '0;
         init_q    <= 1'b1;
         upd       <= 1'b0;
         disp_data <= fmt(24'h0);
      end else begin
         init_q    <= 1'b0;
         upd       <= init_q || (disp_d != disp_data);
         disp_data <= disp_d;
         if (clear) begin
            freeze_q <= 1'b0;
         end else if (lap) begin
            freeze_q <= ~freeze_q;
            if (!freeze_q) begin
               frz_q <= time_bcd;
            end
         end
      end
   end

endmodule
